// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared constants for the D/E forwarding and hazard tracker.
package fwd_hazard_tracker_pkg;

    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned AW_DEF     = 5;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned NSTAGE_DEF = 3;
    localparam int unsigned TW_DEF     = 2;

    // Producer stage indices, youngest first.
    localparam int unsigned STG_E = 0;
    localparam int unsigned STG_M = 1;
    localparam int unsigned STG_W = 2;

    localparam int unsigned FW_SEL_GRF = 0;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port priority match: youngest matching producer decides forward, pending or stall.
module fwd_port_sel
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned TW     = TW_DEF,
    parameter int unsigned SW     = $clog2(NSTAGE_DEF + 1)
) (
    input  logic [NSTAGE-1:0]    ent_vld,
    input  logic [NSTAGE*AW-1:0] ent_addr,
    input  logic [NSTAGE*TW-1:0] ent_tnew,
    input  logic [AW-1:0]        rd_addr,
    input  logic [TW-1:0]        rd_tuse,
    input  logic                 rd_used,
    input  logic [DW-1:0]        grf_rdata,
    input  logic [NSTAGE*DW-1:0] stg_wdata,
    output logic [DW-1:0]        op_data_c,
    output logic                 op_pending_c,
    output logic [SW-1:0]        fw_sel_c,
    output logic                 stall_c
);

    logic          found;
    logic [TW-1:0] hit_tnew;

    // Scan youngest to oldest; the first match masks every older one.
    always_comb begin
        op_data_c    = grf_rdata;
        op_pending_c = 1'b0;
        fw_sel_c     = SW'(FW_SEL_GRF);
        stall_c      = 1'b0;
        found        = 1'b0;
        hit_tnew     = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (!found && ent_vld[k] && (rd_addr != '0) &&
                (ent_addr[k*AW +: AW] == rd_addr)) begin
                found    = 1'b1;
                hit_tnew = ent_tnew[k*TW +: TW];
                if (hit_tnew == '0) begin
                    op_data_c = stg_wdata[k*DW +: DW];
                    fw_sel_c  = SW'(k + 1);
                end else if (hit_tnew <= rd_tuse) begin
                    op_pending_c = 1'b1;
                end else begin
                    stall_c = rd_used;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// In-flight writer shift register at the D/E boundary; per-port forwarding via fwd_port_sel.
module fwd_hazard_tracker
    import fwd_hazard_tracker_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned TW     = TW_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             iss_we,
    input  logic [AW-1:0]                    iss_addr,
    input  logic [TW-1:0]                    iss_tnew,
    input  logic                             flush,
    input  logic [NRD*AW-1:0]                rd_addr,
    input  logic [NRD*TW-1:0]                rd_tuse,
    input  logic [NRD-1:0]                   rd_used,
    input  logic [NRD*DW-1:0]                grf_rdata,
    input  logic [NSTAGE*DW-1:0]             stg_wdata,
    output logic [NRD*DW-1:0]                op_data,
    output logic [NRD-1:0]                   op_pending,
    output logic [NRD*$clog2(NSTAGE+1)-1:0]  fw_sel,
    output logic                             stall
);

    localparam int unsigned SW = $clog2(NSTAGE + 1);

    if (NSTAGE <= STG_W || STG_M <= STG_E) begin : g_bad_depth
        $error("fwd_hazard_tracker needs at least E, M and W producer stages");
    end

    logic [NSTAGE-1:0]    ent_vld,  ent_vld_nxt;
    logic [NSTAGE*AW-1:0] ent_addr, ent_addr_nxt;
    logic [NSTAGE*TW-1:0] ent_tnew, ent_tnew_nxt;
    logic [NRD-1:0]       port_stall;

    assign stall = |port_stall;

    // Shift toward W with saturating Tnew countdown; stall injects a bubble, flush clears all.
    always_comb begin
        ent_vld_nxt  = '0;
        ent_addr_nxt = ent_addr;
        ent_tnew_nxt = ent_tnew;
        ent_addr_nxt[STG_E*AW +: AW] = iss_addr;
        ent_tnew_nxt[STG_E*TW +: TW] = iss_tnew;
        for (int unsigned k = 1; k < NSTAGE; k++) begin
            ent_addr_nxt[k*AW +: AW] = ent_addr[(k-1)*AW +: AW];
            ent_tnew_nxt[k*TW +: TW] = (ent_tnew[(k-1)*TW +: TW] == '0) ? '0 :
                                       ent_tnew[(k-1)*TW +: TW] - TW'(1);
        end
        if (!flush) begin
            ent_vld_nxt[STG_E] = iss_we & (iss_addr != '0) & ~stall;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                ent_vld_nxt[k] = ent_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_vld  <= '0;
            ent_addr <= '0;
            ent_tnew <= '0;
        end else begin
            ent_vld  <= ent_vld_nxt;
            ent_addr <= ent_addr_nxt;
            ent_tnew <= ent_tnew_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_port_sel #(
            .DW     (DW),
            .AW     (AW),
            .NSTAGE (NSTAGE),
            .TW     (TW),
            .SW     (SW)
        ) u_sel (
            .ent_vld      (ent_vld),
            .ent_addr     (ent_addr),
            .ent_tnew     (ent_tnew),
            .rd_addr      (rd_addr[p*AW +: AW]),
            .rd_tuse      (rd_tuse[p*TW +: TW]),
            .rd_used      (rd_used[p]),
            .grf_rdata    (grf_rdata[p*DW +: DW]),
            .stg_wdata    (stg_wdata),
            .op_data_c    (op_data[p*DW +: DW]),
            .op_pending_c (op_pending[p]),
            .fw_sel_c     (fw_sel[p*SW +: SW]),
            .stall_c      (port_stall[p])
        );
    end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Table-driven cycle bench for fwd_hazard_tracker with an expected-result queue.
module tb_fwd_hazard_tracker;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NRD = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned TW = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned NV = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              iss_we;
    logic [AW-1:0]     iss_addr;
    logic [TW-1:0]     iss_tnew;
    logic              flush;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*TW-1:0] rd_tuse;
    logic [NRD-1:0]    rd_used;
    logic [NRD*DW-1:0] grf_rdata;
    logic [NS*DW-1:0]  stg_wdata;
    logic [NRD*DW-1:0] op_data;
    logic [NRD-1:0]    op_pending;
    logic [NRD*SW-1:0] fw_sel;
    logic              stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] ia;
        logic [TW-1:0] it;
        logic          fl;
        logic [AW-1:0] a0;
        logic [TW-1:0] u0;
        logic          us0;
        logic [AW-1:0] a1;
        logic [TW-1:0] u1;
        logic          us1;
        logic          st;
        logic [SW-1:0] s0;
        logic          p0;
        logic [SW-1:0] s1;
        logic          p1;
    } vec_t;

    typedef struct {
        logic          st;
        logic [SW-1:0] s0;
        logic          p0;
        logic [SW-1:0] s1;
        logic          p1;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb_q [$];

    fwd_hazard_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .iss_we     (iss_we),
        .iss_addr   (iss_addr),
        .iss_tnew   (iss_tnew),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_tuse    (rd_tuse),
        .rd_used    (rd_used),
        .grf_rdata  (grf_rdata),
        .stg_wdata  (stg_wdata),
        .op_data    (op_data),
        .op_pending (op_pending),
        .fw_sel     (fw_sel),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic we, input int ia, input int it, input logic fl,
                                input int a0, input int u0, input logic us0,
                                input int a1, input int u1, input logic us1,
                                input logic st, input int s0, input logic p0,
                                input int s1, input logic p1);
        vec_t v;
        v.we = we; v.ia = AW'(ia); v.it = TW'(it); v.fl = fl;
        v.a0 = AW'(a0); v.u0 = TW'(u0); v.us0 = us0;
        v.a1 = AW'(a1); v.u1 = TW'(u1); v.us1 = us1;
        v.st = st; v.s0 = SW'(s0); v.p0 = p0; v.s1 = SW'(s1); v.p1 = p1;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        iss_we   = v.we;
        iss_addr = v.ia;
        iss_tnew = v.it;
        flush    = v.fl;
        rd_addr  = {v.a1, v.a0};
        rd_tuse  = {v.u1, v.u0};
        rd_used  = {v.us1, v.us0};
    endtask

    task automatic expect_out(input logic st, input int s0, input logic p0,
                              input int s1, input logic p1);
        exp_t e;
        e.st = st; e.s0 = SW'(s0); e.p0 = p0; e.s1 = SW'(s1); e.p1 = p1;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string name);
        exp_t          e;
        logic [SW-1:0] es;
        logic          ep;
        logic [DW-1:0] ed;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got no expectation want one", name);
            return;
        end
        e = sb_q.pop_front();
        if (stall !== e.st) begin
            errors++;
            $display("FAIL %s stall: got %0b want %0b", name, stall, e.st);
        end
        for (int p = 0; p < NRD; p++) begin
            es = (p == 0) ? e.s0 : e.s1;
            ep = (p == 0) ? e.p0 : e.p1;
            ed = (es == '0) ? grf_rdata[p*DW +: DW] : stg_wdata[(int'(es) - 1)*DW +: DW];
            checks++;
            if (fw_sel[p*SW +: SW] !== es) begin
                errors++;
                $display("FAIL %s fw_sel[%0d]: got %0d want %0d", name, p, fw_sel[p*SW +: SW], es);
            end
            checks++;
            if (op_pending[p] !== ep) begin
                errors++;
                $display("FAIL %s op_pending[%0d]: got %0b want %0b", name, p, op_pending[p], ep);
            end
            if (!ep) begin
                checks++;
                if (op_data[p*DW +: DW] !== ed) begin
                    errors++;
                    $display("FAIL %s op_data[%0d]: got %08h want %08h", name, p, op_data[p*DW +: DW], ed);
                end
            end
        end
    endtask

    initial begin
        //           we ia it fl  a0 u0 us0  a1 u1 us1  st s0 p0 s1 p1
        tbl[0]  = mk(0, 0, 0, 0,  5, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 0, 0,  5, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,  5, 0, 1,   0, 0, 0,   0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0,  5, 0, 1,   0, 0, 0,   0, 2, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,  5, 0, 1,   0, 0, 0,   0, 3, 0, 0, 0);
        tbl[5]  = mk(1, 8, 2, 0,  0, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 9, 1, 0,  8, 0, 1,   0, 0, 0,   1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 9, 1, 0,  8, 0, 1,   0, 0, 0,   1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 9, 1, 0,  8, 0, 1,   9, 0, 1,   0, 3, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0,  9, 1, 1,   0, 0, 0,   0, 0, 1, 0, 0);
        tbl[10] = mk(1, 3, 1, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[11] = mk(1, 3, 1, 0,  0, 0, 0,   9, 0, 1,   0, 0, 0, 3, 0);
        tbl[12] = mk(1, 0, 2, 0,  3, 1, 1,   0, 0, 0,   0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 1,   3, 0, 1,   0, 0, 0, 2, 0);
        tbl[14] = mk(1, 7, 2, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[15] = mk(1, 10, 1, 1, 7, 0, 1,   0, 0, 0,   1, 0, 0, 0, 0);
        tbl[16] = mk(1, 10, 1, 0, 7, 0, 1,   0, 0, 0,   0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,  10, 0, 1,  10, 1, 1,  1, 0, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 0,  10, 0, 1,  10, 1, 1,  0, 2, 0, 2, 0);

        grf_rdata = {32'h6666_0001, 32'h6666_0000};
        stg_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        reset = 1'b0;
        apply(mk(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state: GRF path on every port, no stall.
        repeat (2) @(negedge clk);
        expect_out(0, 0, 0, 0, 0);
        compare_out("in_reset");
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(tbl[i]);
            expect_out(tbl[i].st, int'(tbl[i].s0), tbl[i].p0, int'(tbl[i].s1), tbl[i].p1);
            @(negedge clk);
            compare_out($sformatf("row%0d", i));
        end

        // r10 now sits in W with Tnew 0; an async reset must drop it at once.
        @(posedge clk);
        #1;
        apply(mk(0, 0, 0, 0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        expect_out(0, 3, 0, 0, 0);
        compare_out("pre_async_reset");
        reset = 1'b0;
        #1;
        expect_out(0, 0, 0, 0, 0);
        compare_out("async_reset_drop");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_out(0, 0, 0, 0, 0);
        compare_out("after_reset_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
